// File: rtl/decoder_seq.sv
// decoder_seq: paced 3-to-8 decoder with a 2-entry input queue; each code shows one-hot on y for HOLD cycles.
// Define DECODER_PARITY_EN to store in_par and drop entries failing even parity at pop.
module decoder_seq #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_par,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       busy,
    output logic       par_err
);
`ifdef DECODER_PARITY_EN
    localparam int W = 4;
`else
    localparam int W = 3;
`endif
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t       state, state_d;
    logic [W-1:0] mem [2];
    logic [W-1:0] head;
    logic         wr_ptr, rd_ptr;
    logic [1:0]   count;
    logic [7:0]   cnt, cnt_d, y_d;
    logic         y_valid_d, par_err_d, push, pop, par_ok;

    assign in_ready = count != 2'd2;
    assign push     = in_valid && in_ready;
    assign busy     = (state != S_IDLE) || (count != 2'd0);
    assign head     = mem[rd_ptr];

`ifdef DECODER_PARITY_EN
    assign par_ok = ~^head;
`else
    logic unused_par;
    assign unused_par = in_par;
    assign par_ok     = 1'b1;
`endif

    // A dropped entry still enters HOLD with cnt 0, so it costs exactly one expiry cycle.
    always_comb begin
        state_d   = state;
        y_d       = y;
        y_valid_d = y_valid;
        cnt_d     = cnt;
        par_err_d = 1'b0;
        pop       = 1'b0;
        if (state == S_HOLD && cnt != 8'd0) begin
            cnt_d = cnt - 8'd1;
        end else if (count != 2'd0) begin
            pop       = 1'b1;
            state_d   = S_HOLD;
            y_d       = par_ok ? 8'd1 << head[2:0] : 8'd0;
            y_valid_d = par_ok;
            cnt_d     = par_ok ? HOLD_M1 : 8'd0;
            par_err_d = !par_ok;
        end else begin
            state_d   = S_IDLE;
            y_d       = 8'd0;
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            y       <= 8'd0;
            y_valid <= 1'b0;
            cnt     <= 8'd0;
            par_err <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            state   <= state_d;
            y       <= y_d;
            y_valid <= y_valid_d;
            cnt     <= cnt_d;
            par_err <= par_err_d;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
`ifdef DECODER_PARITY_EN
        if (push)
            mem[wr_ptr] <= {in_par, in_code};
`else
        if (push)
            mem[wr_ptr] <= in_code;
`endif
    end
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed checks of decoder_seq with HOLD=4 and HOLD=1 instances.
module tb_decoder_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v4 = 1'b0, p4 = 1'b0, v1 = 1'b0, p1 = 1'b0;
    logic [2:0] c4 = 3'd0, c1 = 3'd0;
    logic       r4, yv4, b4, pe4, r1, yv1, b1, pe1;
    logic [7:0] y4, y1, ey;
    logic [7:0] obs [64];
    logic       ep;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    decoder_seq #(.HOLD(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_code(c4), .in_par(p4),
        .y(y4), .y_valid(yv4), .busy(b4), .par_err(pe4)
    );

    decoder_seq #(.HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_code(c1), .in_par(p1),
        .y(y1), .y_valid(yv1), .busy(b1), .par_err(pe1)
    );

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            v4 = 1'($urandom);
            c4 = 3'($urandom);
            p4 = 1'($urandom);
            v1 = 1'($urandom);
            c1 = 3'($urandom);
            @(negedge clk);
            checks++;
            if ({y4, yv4, r4, b4, pe4} !== {8'h00, 4'b0100}) begin
                errors++;
                $display("FAIL reset_u4 got y=%h v=%b rdy=%b busy=%b perr=%b want y=00 v=0 rdy=1 busy=0 perr=0", y4, yv4, r4, b4, pe4);
            end
            checks++;
            if ({y1, yv1, r1, b1, pe1} !== {8'h00, 4'b0100}) begin
                errors++;
                $display("FAIL reset_u1 got y=%h v=%b rdy=%b busy=%b perr=%b want y=00 v=0 rdy=1 busy=0 perr=0", y1, yv1, r1, b1, pe1);
            end
        end
        v4 = 1'b0;
        v1 = 1'b0;
        p4 = 1'b0;
        p1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        v4 = 1'b1;
        c4 = 3'd5;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        checks++;
        if (y4 !== 8'h00) begin
            errors++;
            $display("FAIL single_latency got y=%h want 00", y4);
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checks++;
            if (y4 !== 8'h20 || yv4 !== 1'b1) begin
                errors++;
                $display("FAIL single_hold[%0d] got y=%h v=%b want y=20 v=1", t, y4, yv4);
            end
        end
        @(negedge clk);
        checks++;
        if (y4 !== 8'h00 || yv4 !== 1'b0 || b4 !== 1'b0) begin
            errors++;
            $display("FAIL single_end got y=%h v=%b busy=%b want y=00 v=0 busy=0", y4, yv4, b4);
        end
    endtask

    task automatic test_stream;
        int  idx = 0;
        bit  saw_low = 0;
        bit  go;
        v4 = 1'b1;
        c4 = 3'd0;
        for (int t = 0; t < 45; t++) begin
            if (!r4)
                saw_low = 1;
            go = v4 && r4;
            @(posedge clk);
            @(negedge clk);
            obs[t] = y4;
            if (go) begin
                idx++;
                if (idx == 8)
                    v4 = 1'b0;
                else
                    c4 = idx[2:0];
            end
        end
        checks++;
        if (obs[0] !== 8'h00) begin
            errors++;
            $display("FAIL stream_first got y=%h want 00", obs[0]);
        end
        for (int i = 0; i < 32; i++) begin
            ey = 8'h01 << (i / 4);
            checks++;
            if (obs[i+1] !== ey) begin
                errors++;
                $display("FAIL stream_y[%0d] got %h want %h", i, obs[i+1], ey);
            end
        end
        checks++;
        if (obs[33] !== 8'h00 || b4 !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got y=%h busy=%b want y=00 busy=0", obs[33], b4);
        end
        checks++;
        if (idx != 8 || !saw_low) begin
            errors++;
            $display("FAIL stream_handshake got accepted=%0d ready_low=%0d want 8 and 1", idx, saw_low);
        end
    endtask

    task automatic test_async_reset;
        v4 = 1'b1;
        c4 = 3'd1;
        @(posedge clk);
        @(negedge clk);
        c4 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        c4 = 3'd3;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        checks++;
        if (y4 !== 8'h02 || r4 !== 1'b0) begin
            errors++;
            $display("FAIL arst_pre got y=%h rdy=%b want y=02 rdy=0", y4, r4);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({y4, yv4, r4, b4} !== {8'h00, 3'b010}) begin
            errors++;
            $display("FAIL arst_now got y=%h v=%b rdy=%b busy=%b want y=00 v=0 rdy=1 busy=0", y4, yv4, r4, b4);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (y4 !== 8'h00 || b4 !== 1'b0) begin
            errors++;
            $display("FAIL arst_after got y=%h busy=%b want y=00 busy=0", y4, b4);
        end
    endtask

    task automatic test_parity;
        v4 = 1'b1;
        c4 = 3'd3;
        p4 = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef DECODER_PARITY_EN
            ey = (t >= 2 && t <= 5) ? 8'h08 : 8'h00;
            ep = (t == 1);
`else
            ey = (t >= 1 && t <= 8) ? 8'h08 : 8'h00;
            ep = 1'b0;
`endif
            checks++;
            if (y4 !== ey || pe4 !== ep) begin
                errors++;
                $display("FAIL parity[%0d] got y=%h perr=%b want y=%h perr=%b", t, y4, pe4, ey, ep);
            end
            if (t == 0)
                p4 = 1'b0;
            if (t == 1)
                v4 = 1'b0;
        end
    endtask

    task automatic test_hold1;
        logic [2:0] codes [4] = '{3'd7, 3'd0, 3'd7, 3'd0};
        logic [7:0] want  [7] = '{8'h00, 8'h80, 8'h01, 8'h80, 8'h01, 8'h00, 8'h00};
        int idx = 0;
        bit go;
        v1 = 1'b1;
        c1 = codes[0];
        for (int t = 0; t < 7; t++) begin
            go = v1 && r1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (y1 !== want[t]) begin
                errors++;
                $display("FAIL hold1_y[%0d] got %h want %h", t, y1, want[t]);
            end
            if (go) begin
                idx++;
                if (idx == 4)
                    v1 = 1'b0;
                else
                    c1 = codes[idx];
            end
        end
        checks++;
        if (b1 !== 1'b0) begin
            errors++;
            $display("FAIL hold1_busy got %b want 0", b1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_async_reset();
        test_parity();
        test_hold1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
